// File: rtl/pipelined_control_decoder.sv
// RV32I control decoder registered at the ID/EX boundary.
// Valid/ready handshake with stall, flush and a saturating illegal-instruction counter.
module pipelined_control_decoder #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [4:0]       rd_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [2:0]       funct3_o,
  output logic             funct7b5_o,
  output logic             Branch_o,
  output logic             Jump_o,
  output logic             JumpReg_o,
  output logic             MemWrite_o,
  output logic             ALUSrc_o,
  output logic             ALUASrc_o,
  output logic             RegWrite_o,
  output logic [1:0]       ResultSrc_o,
  output logic [2:0]       ImmSrc_o,
  output logic [1:0]       ALUOp_o,
  output logic             Illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  // Bundle order: branch, jump, jump_reg, mem_write, alu_src, alu_a_src, reg_write,
  // result_src[1:0], imm_src[2:0], alu_op[1:0], illegal
  localparam int unsigned CtrlW = 15;

  logic             branch, jump, jump_reg, mem_write, alu_src, alu_a_src, reg_write, illegal;
  logic [1:0]       result_src, alu_op;
  logic [2:0]       imm_src;
  logic [CtrlW-1:0] dec_ctrl;
  logic             accept;
  logic             unused_instr_bits;

  logic             valid_q;
  logic [CtrlW-1:0] ctrl_q;
  logic [XLEN-1:0]  pc_q;
  logic [4:0]       rd_q, rs1_q, rs2_q;
  logic [2:0]       funct3_q;
  logic             funct7b5_q;
  logic [CNT_W-1:0] cnt_q;

  assign unused_instr_bits = ^{instr_i[31], instr_i[29:25]};

  always_comb begin
    branch     = 1'b0;
    jump       = 1'b0;
    jump_reg   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    alu_a_src  = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    imm_src    = 3'b000;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    // Full 7-bit match also enforces instr[1:0] == 2'b11
    unique case (instr_i[6:0])
      7'b0110011: begin reg_write = 1'b1; alu_op = 2'b10; end
      7'b0000011: begin reg_write = 1'b1; alu_src = 1'b1; result_src = 2'b01; end
      7'b0010011: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b10; end
      7'b0100011: begin mem_write = 1'b1; alu_src = 1'b1; imm_src = 3'b001; end
      7'b1100011: begin branch = 1'b1; imm_src = 3'b010; alu_op = 2'b01; end
      7'b0010111: begin
        reg_write = 1'b1; alu_src = 1'b1; alu_a_src = 1'b1; imm_src = 3'b011;
      end
      7'b0110111: begin reg_write = 1'b1; imm_src = 3'b011; result_src = 2'b11; end
      7'b1100111: begin reg_write = 1'b1; alu_src = 1'b1; jump_reg = 1'b1; result_src = 2'b10; end
      7'b1101111: begin reg_write = 1'b1; jump = 1'b1; imm_src = 3'b100; result_src = 2'b10; end
      default:    illegal = 1'b1;
    endcase
  end

  assign dec_ctrl = {branch, jump, jump_reg, mem_write, alu_src, alu_a_src, reg_write,
                     result_src, imm_src, alu_op, illegal};

  assign in_ready_o = !valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (flush_i) begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
      end else if (accept) begin
        valid_q    <= 1'b1;
        ctrl_q     <= dec_ctrl;
        pc_q       <= pc_i;
        rd_q       <= instr_i[11:7];
        rs1_q      <= instr_i[19:15];
        rs2_q      <= instr_i[24:20];
        funct3_q   <= instr_i[14:12];
        funct7b5_q <= instr_i[30];
      end else if (out_ready_i) begin
        valid_q <= 1'b0;
      end
      if (accept && illegal && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Gate controls with valid so a bubble never carries a stale write enable
  assign {Branch_o, Jump_o, JumpReg_o, MemWrite_o, ALUSrc_o, ALUASrc_o, RegWrite_o,
          ResultSrc_o, ImmSrc_o, ALUOp_o, Illegal_o} = valid_q ? ctrl_q : '0;

  assign out_valid_o   = valid_q;
  assign pc_o          = pc_q;
  assign rd_o          = rd_q;
  assign rs1_o         = rs1_q;
  assign rs2_o         = rs2_q;
  assign funct3_o      = funct3_q;
  assign funct7b5_o    = funct7b5_q;
  assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipelined_control_decoder.sv
// Bench for pipelined_control_decoder: directed cases plus randomized traffic
// compared every cycle against a behavioural model of the stage.
module tb_pipelined_control_decoder;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [31:0]      instr_i = '0;
  logic [XLEN-1:0]  pc_i = '0;
  logic             flush_i = 1'b0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [XLEN-1:0]  pc_o;
  logic [4:0]       rd_o, rs1_o, rs2_o;
  logic [2:0]       funct3_o;
  logic             funct7b5_o;
  logic             Branch_o, Jump_o, JumpReg_o, MemWrite_o, ALUSrc_o, ALUASrc_o, RegWrite_o;
  logic [1:0]       ResultSrc_o, ALUOp_o;
  logic [2:0]       ImmSrc_o;
  logic             Illegal_o;
  logic [CNT_W-1:0] illegal_cnt_o;

  pipelined_control_decoder #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .pc_o(pc_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .funct3_o(funct3_o), .funct7b5_o(funct7b5_o), .Branch_o(Branch_o), .Jump_o(Jump_o),
    .JumpReg_o(JumpReg_o), .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o),
    .ALUASrc_o(ALUASrc_o), .RegWrite_o(RegWrite_o), .ResultSrc_o(ResultSrc_o),
    .ImmSrc_o(ImmSrc_o), .ALUOp_o(ALUOp_o), .Illegal_o(Illegal_o),
    .illegal_cnt_o(illegal_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       br, jmp, jr, mw, asrc, aasrc, rw;
    logic [1:0] res;
    logic [2:0] imm;
    logic [1:0] aop;
    logic       ill;
  } ctrl_t;

  int n_checks = 0;
  int n_fail   = 0;
  bit run_cmp  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode table written from the opcode class list
  function automatic ctrl_t model_dec(input logic [31:0] ins);
    ctrl_t c;
    c = '0;
    if (ins[1:0] != 2'b11) begin
      c.ill = 1'b1;
    end else begin
      case (ins[6:2])
        5'b01100: begin c.rw = 1; c.aop = 2; end
        5'b00000: begin c.rw = 1; c.asrc = 1; c.res = 1; end
        5'b00100: begin c.rw = 1; c.asrc = 1; c.aop = 2; end
        5'b01000: begin c.mw = 1; c.asrc = 1; c.imm = 1; end
        5'b11000: begin c.br = 1; c.imm = 2; c.aop = 1; end
        5'b00101: begin c.rw = 1; c.asrc = 1; c.aasrc = 1; c.imm = 3; end
        5'b01101: begin c.rw = 1; c.imm = 3; c.res = 3; end
        5'b11001: begin c.rw = 1; c.asrc = 1; c.jr = 1; c.res = 2; end
        5'b11011: begin c.rw = 1; c.jmp = 1; c.imm = 4; c.res = 2; end
        default:  c.ill = 1'b1;
      endcase
    end
    return c;
  endfunction

  // Model state: one-entry holding slot plus counter
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  int          m_cnt;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_valid = 0; m_instr = '0; m_pc = '0; m_cnt = 0;
    end else begin
      bit acc;
      acc = in_valid_i && (!m_valid || out_ready_i) && !flush_i;
      if (acc && model_dec(instr_i).ill && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
      if (flush_i)          m_valid = 0;
      else if (acc)         begin m_valid = 1; m_instr = instr_i; m_pc = pc_i; end
      else if (out_ready_i) m_valid = 0;
    end
  end

  ctrl_t got;
  assign got = {Branch_o, Jump_o, JumpReg_o, MemWrite_o, ALUSrc_o, ALUASrc_o, RegWrite_o,
                ResultSrc_o, ImmSrc_o, ALUOp_o, Illegal_o};

  always @(negedge clk_i) begin
    if (!rst_i && run_cmp) begin
      check("in_ready", 64'(in_ready_o), 64'(!m_valid || out_ready_i));
      check("out_valid", 64'(out_valid_o), 64'(m_valid));
      check("ctrl", 64'(got), m_valid ? 64'(model_dec(m_instr)) : 64'd0);
      check("illegal_cnt", 64'(illegal_cnt_o), 64'(m_cnt));
      if (m_valid) begin
        check("pc", 64'(pc_o), 64'(m_pc));
        check("fields", 64'({rd_o, rs1_o, rs2_o, funct3_o, funct7b5_o}),
              64'({m_instr[11:7], m_instr[19:15], m_instr[24:20], m_instr[14:12], m_instr[30]}));
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    in_valid_i = v; instr_i = ins; pc_i = pc; out_ready_i = rdy; flush_i = fl;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [6:0]  ops [9] = '{7'h33, 7'h03, 7'h13, 7'h23, 7'h63, 7'h17, 7'h37, 7'h67, 7'h6f};
  logic [31:0] r;
  logic [31:0] pc_hold;

  initial begin
    #3;
    check("rst out_valid", 64'(out_valid_o), 0);
    check("rst ctrl", 64'(got), 0);
    check("rst cnt", 64'(illegal_cnt_o), 0);
    check("rst pc/rd", 64'({pc_o, rd_o}), 0);
    #9;
    rst_i = 0;
    run_cmp = 1;

    // Back-to-back I / store / branch at full throughput
    drive(1, 32'h00500093, 32'h100, 1, 0);
    tick();
    check("addi ctrl", 64'({RegWrite_o, ALUSrc_o, ALUOp_o, rd_o}), 64'({1'b1, 1'b1, 2'b10, 5'd1}));
    check("addi rdy", 64'({out_valid_o, in_ready_o}), 64'b11);
    drive(1, 32'h0020A023, 32'h104, 1, 0);
    tick();
    check("sw ctrl", 64'({MemWrite_o, ImmSrc_o, RegWrite_o}), 64'({1'b1, 3'b001, 1'b0}));
    check("sw rdy", 64'({out_valid_o, in_ready_o}), 64'b11);
    drive(1, 32'h00208463, 32'h108, 1, 0);
    tick();
    check("beq ctrl", 64'({Branch_o, ALUOp_o, ImmSrc_o}), 64'({1'b1, 2'b01, 3'b010}));
    check("beq pc", 64'(pc_o), 64'h108);

    // Upper immediate and jump classes
    drive(1, 32'h008000EF, 32'h10c, 1, 0);
    tick();
    check("jal ctrl", 64'({Jump_o, ResultSrc_o, ImmSrc_o, rd_o}), 64'({1'b1, 2'b10, 3'b100, 5'd1}));
    drive(1, 32'h12345037, 32'h110, 1, 0);
    tick();
    check("lui ctrl", 64'({ResultSrc_o, ImmSrc_o}), 64'({2'b11, 3'b011}));
    drive(1, 32'h00000517, 32'h114, 1, 0);
    tick();
    check("auipc ctrl", 64'({ALUASrc_o, ALUSrc_o, RegWrite_o}), 64'b111);

    // Backpressure: three stalled cycles, then release
    drive(1, 32'h00500093, 32'h200, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("stall ready", 64'(in_ready_o), 0);
      tick();
      check("stall hold", 64'({out_valid_o, pc_o, ALUASrc_o}), 64'({1'b1, 32'h114, 1'b1}));
    end
    out_ready_i = 1;
    #1;
    check("release ready", 64'(in_ready_o), 1);
    tick();
    check("release next", 64'({out_valid_o, pc_o}), 64'({1'b1, 32'h200}));

    // Flush overrides both the held entry and the incoming one
    drive(1, 32'h0020A023, 32'h300, 0, 1);
    tick();
    check("flush valid", 64'(out_valid_o), 0);
    check("flush ctrl", 64'(got), 0);
    drive(0, 32'h0, 32'h0, 1, 0);
    tick();
    check("flush dropped", 64'(out_valid_o), 0);

    // Illegal sequence with a flushed illegal in between
    drive(1, 32'hFFFFFFFF, 32'h400, 1, 0);
    tick();
    check("ill 1", 64'({Illegal_o, RegWrite_o, MemWrite_o, illegal_cnt_o}), 64'({3'b100, 2'd1}));
    drive(1, 32'hFFFFFFFF, 32'h404, 1, 1);
    tick();
    check("ill flushed", 64'({out_valid_o, illegal_cnt_o}), 64'({1'b0, 2'd1}));
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hFFFFFFFF, 32'h408 + 32'(4 * i), 1, 0);
      tick();
      check("ill sat", 64'({Illegal_o, illegal_cnt_o}), 64'({1'b1, (i == 0) ? 2'd2 : 2'd3}));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      if ($urandom_range(0, 9) < 7) r = {r[31:7], ops[$urandom_range(0, 8)]};
      drive(($urandom_range(0, 3) != 0), r, $urandom(), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) == 0));
      tick();
    end

    // Asynchronous reset in the middle of a valid entry
    drive(1, 32'h00500093, 32'h500, 1, 0);
    tick();
    check("pre-rst", 64'({out_valid_o, RegWrite_o, illegal_cnt_o}), 64'({2'b11, 2'd3}));
    pc_hold = pc_o;
    #2;
    rst_i = 1;
    #1;
    check("async rst", 64'({out_valid_o, RegWrite_o, illegal_cnt_o, pc_o}), 0);
    drive(0, 32'h0, 32'h0, 1, 0);
    #3;
    rst_i = 0;
    tick();
    tick();
    check("post-rst idle", 64'({out_valid_o, illegal_cnt_o}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
